// File: rtl/score_digit_sequencer.sv
// Score-to-BCD sequencer: shift-add-3 conversion into a double-buffered display,
// plus registered pixel decode that locates the digit box under the VGA beam.
module score_digit_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int TOP_LEFT_X = 16,
  parameter int TOP_LEFT_Y = 8,
  parameter int DIGIT_W    = 32,
  parameter int DIGIT_H    = 64,
  parameter int DIGIT_GAP  = 4,
  parameter int BLANK_LZ   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  output logic               busy,
  output logic               InsideRectangle,
  output logic [10:0]        offsetX,
  output logic [10:0]        offsetY,
  output logic [3:0]         digit
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int PITCH = DIGIT_W + DIGIT_GAP;
  localparam longint unsigned MAX_VAL = 64'(10 ** NUM_DIGITS) - 64'd1;
  localparam logic [31:0] TOP_Y = 32'(TOP_LEFT_Y);
  localparam logic [31:0] BOT_Y = 32'(TOP_LEFT_Y + DIGIT_H - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Scores beyond what the digit row can show are clamped to all nines.
  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
    if (64'(s) > MAX_VAL) sat = SCORE_W'(MAX_VAL);
    else                  sat = s;
  endfunction

  function automatic logic [SR_W-1:0] load_sr(input logic [SCORE_W-1:0] s);
    load_sr = {{BCD_W{1'b0}}, sat(s)};
  endfunction

  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (t[SCORE_W + 4*n +: 4] >= 4'd5)
        t[SCORE_W + 4*n +: 4] = t[SCORE_W + 4*n +: 4] + 4'd3;
    end
    dabble = {t[SR_W-2:0], 1'b0};
  endfunction

  state_t             state_q;
  logic [SR_W-1:0]    sr_q;
  logic [SR_W-1:0]    sr_step_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               pend_q;
  logic [SCORE_W-1:0] pend_val_q;
  logic [BCD_W-1:0]   disp_q;
  logic               busy_q;

  assign sr_step_d = dabble(sr_q);
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          // A strobe landing in DONE leaves a pending value to start from here.
          if (score_valid) begin
            sr_q    <= load_sr(score);
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= SHIFT;
          end else if (pend_q) begin
            sr_q    <= load_sr(pend_val_q);
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_step_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SCORE_W - 1)) state_q <= DONE;
          if (score_valid) begin
            pend_q     <= 1'b1;
            pend_val_q <= score;
          end
        end
        DONE: begin
          disp_q <= sr_q[SR_W-1 -: BCD_W];
          if (pend_q) begin
            sr_q    <= load_sr(pend_val_q);
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
          pend_q <= score_valid;
          if (score_valid) pend_val_q <= score;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [NUM_DIGITS-1:0] hit;
  logic [NUM_DIGITS-1:0] zero_pref;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            box_dig  [NUM_DIGITS];
  logic [10:0]           offx_box [NUM_DIGITS];
  logic                  in_y;

  assign in_y = ({21'd0, pixelY} >= TOP_Y) && ({21'd0, pixelY} <= BOT_Y);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_box
      localparam logic [31:0] LEFT  = 32'(TOP_LEFT_X + gi * PITCH);
      localparam logic [31:0] RIGHT = LEFT + 32'(DIGIT_W - 1);
      logic in_x;

      assign box_dig[gi] = disp_q[BCD_W-1-4*gi -: 4];
      if (gi == 0) begin : g_first
        assign zero_pref[gi] = (box_dig[gi] == 4'd0);
      end else begin : g_rest
        assign zero_pref[gi] = zero_pref[gi-1] && (box_dig[gi] == 4'd0);
      end
      // The last digit is never blanked so a zero score still shows "0".
      assign blank[gi]    = (BLANK_LZ != 0) && (gi != NUM_DIGITS - 1) && zero_pref[gi];
      assign in_x         = ({21'd0, pixelX} >= LEFT) && ({21'd0, pixelX} <= RIGHT);
      assign hit[gi]      = in_x && in_y && !blank[gi];
      assign offx_box[gi] = pixelX - 11'(LEFT);
    end
  endgenerate

  logic        ir_d;
  logic [10:0] offx_d;
  logic [10:0] offy_d;
  logic [3:0]  dig_d;

  // Boxes never overlap, so OR-combining the hit box's fields is a clean mux.
  always_comb begin
    ir_d   = |hit;
    offx_d = '0;
    dig_d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hit[i]) begin
        offx_d = offx_d | offx_box[i];
        dig_d  = dig_d | box_dig[i];
      end
    end
    offy_d = ir_d ? (pixelY - 11'(TOP_LEFT_Y)) : 11'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
      digit           <= '0;
    end else begin
      InsideRectangle <= ir_d;
      offsetX         <= offx_d;
      offsetY         <= offy_d;
      digit           <= dig_d;
    end
  end

endmodule
